hack_cpu_mc: RTL and testbench



---
 rtl/hack_cpu_mc.sv | 137 +++++++++++++
 tb/tb_hack_cpu_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction and data memory ports.
// Optional illegal C-instruction trap: define HACK_CPU_ILLEGAL_TRAP_EN.
module hack_cpu_mc #(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   AW       = 15,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_valid,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic [AW-1:0] pc,
    output logic          retire,
    output logic          halted
);

    typedef enum logic [2:0] {FETCH, LOAD, EXEC, STORE, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] ir;
    logic [DW-1:0] m_reg;
    logic [DW-1:0] st_data;
    logic [DW-1:0] alu_x;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] alu_f;
    logic [DW-1:0] alu_out;
    logic          zr;
    logic          ng;
    logic          jump_taken;
    logic          illegal;

    assign pc_inc = pc_q + AW'(1);

    always_comb begin
        alu_x = d_reg;
        alu_y = ir[12] ? m_reg : a_reg;
        if (ir[11]) alu_x = '0;
        if (ir[10]) alu_x = ~alu_x;
        if (ir[9])  alu_y = '0;
        if (ir[8])  alu_y = ~alu_y;
        alu_f      = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out    = ir[6] ? ~alu_f : alu_f;
        zr         = (alu_out == '0);
        ng         = alu_out[DW-1];
        jump_taken = (ir[2] && ng) || (ir[1] && zr) || (ir[0] && !ng && !zr);
    end

`ifdef HACK_CPU_ILLEGAL_TRAP_EN
    // Decided on the fetched word itself so the trap is taken on the FETCH exit.
    assign illegal = imem_rdata[DW-1] && (imem_rdata[14:13] != 2'b11);
    assign halted  = (state == HALT);
`else
    assign illegal = 1'b0;
    assign halted  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            a_reg   <= '0;
            d_reg   <= '0;
            ir      <= '0;
            m_reg   <= '0;
            st_addr <= '0;
            st_data <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        ir <= imem_rdata;
                        if (illegal)
                            state <= HALT;
                        else if (imem_rdata[DW-1] && imem_rdata[12])
                            state <= LOAD;
                        else
                            state <= EXEC;
                    end
                end
                LOAD: begin
                    if (dmem_ready) begin
                        m_reg <= dmem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ir[DW-1]) begin
                        a_reg <= {1'b0, ir[DW-2:0]};
                        pc_q  <= pc_inc;
                        state <= FETCH;
                    end else begin
                        // Non-blocking updates: jump target and store address see the pre-write A.
                        if (ir[5]) a_reg <= alu_out;
                        if (ir[4]) d_reg <= alu_out;
                        pc_q <= jump_taken ? a_reg[AW-1:0] : pc_inc;
                        if (ir[3]) begin
                            st_addr <= a_reg[AW-1:0];
                            st_data <= alu_out;
                            state   <= STORE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                STORE: begin
                    if (dmem_ready) state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign imem_req   = !reset && (state == FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = !reset && ((state == LOAD) || (state == STORE));
    assign dmem_we    = !reset && (state == STORE);
    assign dmem_addr  = (state == STORE) ? st_addr : a_reg[AW-1:0];
    assign dmem_wdata = st_data;
    assign pc         = pc_q;
    assign retire     = !reset && (((state == EXEC) && !(ir[DW-1] && ir[3])) ||
                                   ((state == STORE) && dmem_ready));

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: scoreboard of expected bus/architectural values.
// Covers HACK_CPU_ILLEGAL_TRAP_EN both defined and undefined.
module tb_hack_cpu_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ready = 1'b0;
    logic [14:0] pc;
    logic        retire;
    logic        halted;

    hack_cpu_mc #(.DW(16), .AW(15), .RESET_PC(15'd0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc(pc), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [14:0] cur_pc = '0;
    int          last_ret = 0;
    int          prev_ret = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val && e.tag == tag) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h (%s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req_we", {dmem_req, dmem_we}, 0);
        chk("rst_retire", retire, 0);
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_a", dut.a_reg, 0);
        chk("rst_d", dut.d_reg, 0);
        reset = 1'b0;
        cur_pc = '0;
    endtask

    task automatic do_fetch(input logic [15:0] instr, input int iwait);
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i <= iwait; i++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_no_retire", retire, 0);
            sb_check("fetch_addr", imem_addr);
            if (i < iwait) @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic do_load(input logic [15:0] rdata, input int dwait);
        for (int i = 0; i <= dwait; i++) begin
            chk("load_req_we", {dmem_req, dmem_we}, 2'b10);
            sb_check("load_addr", dmem_addr);
            if (i < dwait) @(negedge clk);
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ready = 1'b0;
        dmem_rdata = '0;
    endtask

    task automatic do_exec();
        sb_check("exec_retire", retire);
        if (retire === 1'b1) begin
            prev_ret = last_ret;
            last_ret = cyc;
        end
        @(negedge clk);
    endtask

    task automatic do_store(input int swait);
        for (int i = 0; i <= swait; i++) begin
            chk("store_req_we", {dmem_req, dmem_we}, 2'b11);
            chk("store_no_retire", retire, 0);
            sb_check("store_addr", dmem_addr);
            sb_check("store_data", dmem_wdata);
            if (i < swait) @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        chk("store_retire", retire, 1);
        @(negedge clk);
        dmem_ready = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] instr, input int iwait,
                             input bit ld, input logic [15:0] ldata, input int dwait,
                             input bit st, input int swait,
                             input logic [14:0] maddr, input logic [15:0] sdata,
                             input logic [14:0] exp_pc, input logic [15:0] exp_a,
                             input logic [15:0] exp_d);
        for (int i = 0; i <= iwait; i++) push("fetch_addr", cur_pc);
        if (ld) for (int i = 0; i <= dwait; i++) push("load_addr", maddr);
        push("exec_retire", st ? 0 : 1);
        if (st) for (int i = 0; i <= swait; i++) begin
            push("store_addr", maddr);
            push("store_data", sdata);
        end
        push("pc", exp_pc);
        push("a", exp_a);
        push("d", exp_d);
        do_fetch(instr, iwait);
        if (ld) do_load(ldata, dwait);
        do_exec();
        if (st) do_store(swait);
        sb_check("pc", pc);
        sb_check("a", dut.a_reg);
        sb_check("d", dut.d_reg);
        cur_pc = exp_pc;
    endtask

    task automatic simple(input logic [15:0] instr, input logic [14:0] exp_pc,
                          input logic [15:0] exp_a, input logic [15:0] exp_d);
        run_instr(instr, 0, 0, '0, 0, 0, 0, '0, '0, exp_pc, exp_a, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // @0 A=5; D=A
        simple(16'h0005, 15'd1, 16'h0005, 16'h0000);
        simple(16'hEC10, 15'd2, 16'h0005, 16'h0005);
        chk("retire_spacing", last_ret - prev_ret, 2);

        // D=M with three wait states on the read
        simple(16'h0064, 15'd3, 16'h0064, 16'h0005);
        run_instr(16'hFC10, 0, 1, 16'h1234, 3, 0, 0, 15'd100, '0, 15'd4, 16'h0064, 16'h1234);

        // M=D-A with A=7, D=9, two wait states on the write
        simple(16'h0009, 15'd5, 16'h0009, 16'h1234);
        simple(16'hEC10, 15'd6, 16'h0009, 16'h0009);
        simple(16'h0007, 15'd7, 16'h0007, 16'h0009);
        run_instr(16'hE4C8, 0, 0, '0, 0, 1, 2, 15'd7, 16'h0002, 15'd8, 16'h0007, 16'h0009);

        // D;JEQ taken and not taken, then unconditional jumps writing A
        simple(16'h0000, 15'd9, 16'h0000, 16'h0009);
        simple(16'hEC10, 15'd10, 16'h0000, 16'h0000);
        simple(16'h0028, 15'd11, 16'h0028, 16'h0000);
        simple(16'hE302, 15'd40, 16'h0028, 16'h0000);
        simple(16'h0001, 15'd41, 16'h0001, 16'h0000);
        simple(16'hEC10, 15'd42, 16'h0001, 16'h0001);
        simple(16'h0028, 15'd43, 16'h0028, 16'h0001);
        simple(16'hE302, 15'd44, 16'h0028, 16'h0001);
        simple(16'hEEA7, 15'd40, 16'hFFFF, 16'h0001);
        simple(16'h0028, 15'd41, 16'h0028, 16'h0001);
        simple(16'hEDA7, 15'd40, 16'hFFD6, 16'h0001);

        // M=M+1 (read then write), with a stalled fetch
        run_instr(16'hFDC8, 2, 1, 16'h00FF, 0, 1, 0, 15'h7FD6, 16'h0100, 15'd41, 16'hFFD6, 16'h0001);

        // PC wrap from 0x7FFF to 0
        simple(16'h7FFF, 15'd42, 16'h7FFF, 16'h0001);
        simple(16'hEA87, 15'h7FFF, 16'h7FFF, 16'h0001);
        simple(16'h0003, 15'd0, 16'h0003, 16'h0001);

        // Reach pc=3 and present 0x8000
        simple(16'h0001, 15'd1, 16'h0001, 16'h0001);
        simple(16'h0002, 15'd2, 16'h0002, 16'h0001);
        simple(16'h0003, 15'd3, 16'h0003, 16'h0001);
`ifdef HACK_CPU_ILLEGAL_TRAP_EN
        push("fetch_addr", cur_pc);
        do_fetch(16'h8000, 0);
        for (int i = 0; i < 5; i++) begin
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, 3);
            chk("halt_reqs", {imem_req, dmem_req, dmem_we}, 0);
            chk("halt_retire", retire, 0);
            @(negedge clk);
        end
        chk("halt_a", dut.a_reg, 16'h0003);
        chk("halt_d", dut.d_reg, 16'h0001);
`else
        simple(16'h8000, 15'd4, 16'h0003, 16'h0001);
        chk("no_trap_halted", halted, 0);
`endif
        do_reset();

        // Reset while a store is stalled
        simple(16'h0011, 15'd1, 16'h0011, 16'h0000);
        simple(16'hEC10, 15'd2, 16'h0011, 16'h0011);
        push("fetch_addr", cur_pc);
        do_fetch(16'hE308, 0);
        chk("pre_store_retire", retire, 0);
        @(negedge clk);
        chk("stalled_store_req_we", {dmem_req, dmem_we}, 2'b11);
        chk("stalled_store_addr", dmem_addr, 15'h0011);
        chk("stalled_store_data", dmem_wdata, 16'h0011);
        reset = 1'b1;
        #1;
        chk("rst_mid_store_req", dmem_req, 0);
        @(negedge clk);
        chk("after_rst_dmem_req", dmem_req, 0);
        chk("after_rst_pc", pc, 0);
        chk("after_rst_a", dut.a_reg, 0);
        chk("after_rst_d", dut.d_reg, 0);
        reset = 1'b0;
        cur_pc = '0;
        simple(16'h0005, 15'd1, 16'h0005, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
